adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Sequencer for the on-chip 8-channel 12-bit ADC macro: on a programmable sample tick it selects the next enabled channel round-robin, pulses start-of-conversion, and waits for end-of-conversion. It then captures the result and presents it as a valid/ready sample stream to the PWM/DAC path or any other consumer. It replaces the free-running hard-wired channel/soc tie-off at top level and owns all ADC control pins.

## Interface
- `SOC_CYCLES`, default 2: cycles `adc_soc` is held high per conversion (≥1).
- `TIMEOUT_CYC`, default 1024: max cycles from `soc` deassert to `eoc` before abort.
- `PERIOD_W`, default 16: width of the `period` input.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; high = scanning enabled.
- `chan_mask` in 8: bit i enables channel i.
- `period` in PERIOD_W: sample interval in `clk` cycles; 0 is treated as 1.
- `adc_soc` out 1: to ADC `soc`.
- `adc_s` out 3: to ADC `s` (channel select).
- `adc_eoc` in 1: from ADC `eoc`, asynchronous to `clk`.
- `adc_dout` in 12: from ADC `dout`, stable while `eoc` is high.
- `smp_valid` out 1, `smp_ready` in 1: sample handshake; transfer when both are high.
- `smp_data` out 12, `smp_chan` out 3: sample payload.
- `busy` out 1: high in any state other than IDLE.
- `err` out 2: sticky; bit0 = timeout, bit1 = overrun.
- `err_clr` in 1: clears `err` (clear wins over a same-cycle set).

## Operation
- `adc_eoc` passes through a 2-flop synchronizer. Completion is the rising edge of the synchronized `eoc`.
- States:
  - IDLE: exit to WAIT when `start`=1 and `chan_mask`≠0.
  - WAIT: tick counter running. On tick, pick the channel and go to SOC. If `start`=0 or mask=0, go to IDLE.
  - SOC: `adc_soc`=1 for SOC_CYCLES cycles, then go to CONV.
  - CONV: wait for the `eoc` rise, then capture `adc_dout` and go to PUSH. If TIMEOUT_CYC elapses, set `err[0]` and go to WAIT with no sample.
  - PUSH: load the output register, then go to WAIT (or IDLE if `start`=0).
- Tick counter:
  - Reloads to `period`-1 on leaving IDLE and on each tick.
  - Counts down every cycle in every non-IDLE state.
  - A tick that fires outside WAIT is remembered, one deep, and consumed on the next WAIT entry.
- Round-robin: the next channel is the lowest enabled index strictly above the last converted channel, wrapping 7→0. After reset the last channel is 7, so the first conversion is the lowest enabled channel. `chan_mask` is sampled at tick time only.
- `adc_s` is registered. It is updated on the tick and held constant through SOC and CONV.
- Output register:
  - Single entry. `smp_valid` stays high until the handshake completes.
  - If PUSH finds `smp_valid`=1 and `smp_ready`=0, the new sample is dropped, the old one is kept, and `err[1]` is set.
  - If `smp_ready`=1 in the same cycle, the old sample transfers and the new one loads with no error.
- `start` falling mid-conversion: the current conversion completes and its sample is pushed, then the block goes to IDLE.
- Reset values: `adc_soc`=0, `adc_s`=0, `smp_valid`=0, `smp_data`=0, `smp_chan`=0, `busy`=0, `err`=0; state IDLE; last channel=7.

## Timing
- From `start` rising (mask≠0): `busy` goes high at cycle +1. The first tick arrives `period` cycles after WAIT entry, and `adc_soc` rises 1 cycle after that tick.
- From the registered-`eoc` rise to `smp_valid`: 2 cycles (CONV→PUSH, PUSH→output register).
- Timeout window is counted from SOC exit.
- Sustained throughput is one sample per max(`period`, SOC_CYCLES + conversion + 5) cycles.

## Structure
- Package `adc_ctrl_pkg`: state encoding constants (IDLE, WAIT, SOC, CONV, PUSH), `ADC_CHANNELS`=8, `ADC_DW`=12, `ADC_CW`=3.
- Sub-module `adc_chan_rr`: combinational next-enabled-channel finder. Inputs: `mask[7:0]`, `last[2:0]`. Outputs: `next[2:0]`, `none`.
- The top FSM, tick counter, timeout counter, synchronizer and output register live in `adc_scan_ctrl`.

## Test plan
- Basic round-robin: mask=8'b0010_0110, period=100, `eoc` model 20 cycles after `soc` falls, `smp_ready`=1. Required: channels 1, 2, 5, 1 in sequence; `smp_data` equals the model value; samples spaced 100 cycles apart.
- Timeout: `eoc` is never raised. Required: `err[0]`=1 exactly TIMEOUT_CYC cycles after SOC exit; no `smp_valid`; next tick proceeds to the next channel. `err_clr` then zeroes `err`.
- Overrun: `smp_ready`=0 for 3 conversions. Required: the first sample is held, `err[1]`=1, and `smp_data` still shows the first sample's value when `ready` rises.
- Simultaneous push and accept: `smp_ready` rises in the PUSH cycle. Required: the old sample transfers, the new one loads, and `err[1]` stays 0.
- `start` dropped during CONV: required: that conversion's sample is delivered, then `busy`=0. Also mask=0 with `start`=1: required: `busy` stays 0.
- Reset mid-CONV (`rst` for 1 cycle): required: all outputs at their reset values on the next cycle, and the next conversion uses the lowest enabled channel.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Imported by adc_scan_ctrl and adc_chan_rr.
package adc_ctrl_pkg;

  localparam int ADC_CHANNELS = 8;
  localparam int ADC_DW       = 12;
  localparam int ADC_CW       = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_SOC  = 3'd2,
    ST_CONV = 3'd3,
    ST_PUSH = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADC_CW-1:0] chan;
    logic [ADC_DW-1:0] data;
  } sample_t;

endpackage

// File: rtl/adc_chan_rr.sv
// Round-robin finder: lowest enabled channel strictly above last.
// Wraps 7 -> 0; returns last itself when it is the only one enabled.
module adc_chan_rr
  import adc_ctrl_pkg::*;
(
  input  logic [ADC_CHANNELS-1:0] mask,
  input  logic [ADC_CW-1:0]       last,
  output logic [ADC_CW-1:0]       next,
  output logic                    none
);

  logic              found;
  logic [ADC_CW-1:0] pos;

  always_comb begin
    next  = last;
    found = 1'b0;
    pos   = last;
    // 3-bit truncation gives the modulo-8 wrap for free
    for (int i = 1; i <= ADC_CHANNELS; i++) begin
      pos = ADC_CW'(int'(last) + i);
      if (!found && mask[pos]) begin
        next  = pos;
        found = 1'b1;
      end
    end
  end

  assign none = ~|mask;

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC scan sequencer: tick-paced round-robin conversions
// delivered as a single-entry valid/ready sample stream.
module adc_scan_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int SOC_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PERIOD_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADC_CHANNELS-1:0] chan_mask,
  input  logic [PERIOD_W-1:0]     period,
  output logic                    adc_soc,
  output logic [ADC_CW-1:0]       adc_s,
  input  logic                    adc_eoc,
  input  logic [ADC_DW-1:0]       adc_dout,
  output logic                    smp_valid,
  input  logic                    smp_ready,
  output logic [ADC_DW-1:0]       smp_data,
  output logic [ADC_CW-1:0]       smp_chan,
  output logic                    busy,
  output logic [1:0]              err,
  input  logic                    err_clr
);

  localparam int SCW = $clog2(SOC_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  state_t              state_nx;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] reload;
  logic                tick_q;
  logic                tick_pend;
  logic                tick_go;
  logic [SCW-1:0]      soc_cnt;
  logic [TOW-1:0]      to_cnt;
  logic [2:0]          eoc_sync;
  logic                eoc_rise;
  logic [ADC_CW-1:0]   last_ch;
  logic [ADC_CW-1:0]   rr_next;
  logic                rr_none;
  logic                scan_on;
  logic                soc_done;
  logic                to_hit;
  logic                to_set;
  logic                ovr_set;
  logic                take;
  sample_t             cap;

  adc_chan_rr u_rr (
    .mask (chan_mask),
    .last (last_ch),
    .next (rr_next),
    .none (rr_none)
  );

  assign reload   = (period == '0) ? '0 : period - 1'b1;
  assign tick_go  = tick_q | tick_pend;
  assign scan_on  = start & ~rr_none;
  assign soc_done = (soc_cnt == SCW'(SOC_CYCLES - 1));
  assign to_hit   = (to_cnt == TOW'(TIMEOUT_CYC - 1));
  assign eoc_rise = eoc_sync[1] & ~eoc_sync[2];
  assign take     = (state == ST_WAIT) && (state_nx == ST_SOC);
  assign to_set   = (state == ST_CONV) & ~eoc_rise & to_hit;
  assign ovr_set  = (state == ST_PUSH) & smp_valid & ~smp_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (scan_on) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!scan_on)     state_nx = ST_IDLE;
        else if (tick_go) state_nx = ST_SOC;
      end
      ST_SOC:  if (soc_done) state_nx = ST_CONV;
      ST_CONV: begin
        if (eoc_rise)    state_nx = ST_PUSH;
        else if (to_hit) state_nx = ST_WAIT;
      end
      ST_PUSH: state_nx = start ? ST_WAIT : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      adc_soc  <= 1'b0;
      eoc_sync <= '0;
      soc_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != ST_IDLE);
      adc_soc  <= (state_nx == ST_SOC);
      eoc_sync <= {eoc_sync[1:0], adc_eoc};
      soc_cnt  <= (state == ST_SOC) ? soc_cnt + 1'b1 : '0;
      to_cnt   <= (state == ST_CONV) ? to_cnt + 1'b1 : '0;
    end
  end

  // Ticks landing outside WAIT are kept one deep until WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      tick_q    <= 1'b0;
      tick_pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      tick_cnt  <= reload;
      tick_q    <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      tick_q   <= (tick_cnt == '0);
      tick_cnt <= (tick_cnt == '0) ? reload : tick_cnt - 1'b1;
      if (state == ST_WAIT) tick_pend <= 1'b0;
      else if (tick_q)      tick_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_s   <= '0;
      last_ch <= ADC_CW'(ADC_CHANNELS - 1);
      cap     <= '0;
    end else begin
      if (take) begin
        adc_s   <= rr_next;
        last_ch <= rr_next;
      end
      if (state == ST_CONV && eoc_rise) begin
        cap.data <= adc_dout;
        cap.chan <= adc_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_valid <= 1'b0;
      smp_data  <= '0;
      smp_chan  <= '0;
    end else begin
      if (smp_valid && smp_ready) smp_valid <= 1'b0;
      if (state == ST_PUSH && !ovr_set) begin
        smp_valid <= 1'b1;
        smp_data  <= cap.data;
        smp_chan  <= cap.chan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= '0;
    else if (err_clr) err <= '0;
    else              err <= err | {ovr_set, to_set};
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: scan table plus random scans checked
// against a round-robin model, and hand sequences for corner cases.
module tb_adc_scan_ctrl;
  import adc_ctrl_pkg::*;

  localparam int SOC_C = 2;
  localparam int TMO   = 64;
  localparam int PW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    chan_mask;
  logic [PW-1:0] period;
  logic          adc_soc;
  logic [2:0]    adc_s;
  logic          adc_eoc = 1'b0;
  logic [11:0]   adc_dout = '0;
  logic          smp_valid;
  logic          smp_ready;
  logic [11:0]   smp_data;
  logic [2:0]    smp_chan;
  logic          busy;
  logic [1:0]    err;
  logic          err_clr;

  adc_scan_ctrl #(
    .SOC_CYCLES (SOC_C),
    .TIMEOUT_CYC(TMO),
    .PERIOD_W   (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .chan_mask(chan_mask),
    .period   (period),
    .adc_soc  (adc_soc),
    .adc_s    (adc_s),
    .adc_eoc  (adc_eoc),
    .adc_dout (adc_dout),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .smp_data (smp_data),
    .smp_chan (smp_chan),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC macro model: data = {channel, conversion number}
  bit          eoc_en = 1'b1;
  int          lat = 10;
  logic        soc_prev = 1'b0;
  int          fall_n = 0;
  int          fall_cyc = -1;
  int          eoc_at = -1;
  int          eoc_hold = 0;
  int          conv_n = 0;
  int          rise_q[$];
  logic [11:0] cur_data = '0;

  always @(negedge clk) begin
    if (eoc_hold > 0) begin
      eoc_hold--;
      if (eoc_hold == 0) adc_eoc = 1'b0;
    end
    if (cyc == eoc_at) begin
      adc_dout = cur_data;
      adc_eoc  = 1'b1;
      eoc_hold = 4;
      eoc_at   = -1;
    end
    if (!soc_prev && adc_soc) begin
      cur_data = {adc_s, 9'(conv_n)};
      conv_n++;
      rise_q.push_back(cyc);
    end
    if (soc_prev && !adc_soc) begin
      fall_n++;
      fall_cyc = cyc;
      if (eoc_en) eoc_at = cyc + lat;
    end
    soc_prev = adc_soc;
  end

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] d;
    int          c;
  } xfer_t;
  xfer_t xq[$];

  always @(negedge clk)
    if (smp_valid && smp_ready) xq.push_back('{smp_chan, smp_data, cyc});

  typedef struct {
    logic [7:0]      mask;
    int              period;
    int              lat;
    int              n;
    bit              tab;
    logic [3:0][2:0] ch;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][2:0] ch4(input int a, b, c, d);
    logic [3:0][2:0] r;
    r[0] = 3'(a);
    r[1] = 3'(b);
    r[2] = 3'(c);
    r[3] = 3'(d);
    return r;
  endfunction

  function automatic logic [2:0] rr(input logic [7:0] m, input int last);
    for (int i = 1; i <= 8; i++)
      if (m[(last + i) % 8]) return 3'((last + i) % 8);
    return 3'(last);
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    chan_mask = '0;
    period    = 16'd1;
    smp_ready = 1'b1;
    err_clr   = 1'b0;
    eoc_en    = 1'b1;
    repeat (50) step();
    rst = 1'b0;
  endtask

  task automatic wait_fall(input int target, input string name);
    for (int t = 0; t < 1500 && fall_n < target; t++) step();
    if (fall_n < target) chk({name, "_fall_wait"}, fall_n, target);
  endtask

  task automatic wait_xfer(input int target, input string name);
    for (int t = 0; t < 4000 && xq.size() < target; t++) step();
    if (xq.size() < target) chk({name, "_xfer_wait"}, xq.size(), target);
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int qb, cb, rb, c0, peff, sp, last;
    logic [2:0] ech;
    do_reset();
    chan_mask = v.mask;
    period    = PW'(v.period);
    lat       = v.lat;
    qb   = xq.size();
    cb   = conv_n;
    rb   = rise_q.size();
    peff = (v.period == 0) ? 1 : v.period;
    sp   = (peff > SOC_C + v.lat + 5) ? peff : SOC_C + v.lat + 5;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    chk({tag, "_busy_pre"}, busy, 0);
    @(negedge clk);
    chk({tag, "_busy_up"}, busy, 1);
    wait_xfer(qb + v.n, tag);
    if (rise_q.size() > rb)
      chk({tag, "_first_soc"}, rise_q[rb], c0 + peff + 2);
    last = 7;
    for (int k = 0; k < v.n && qb + k < xq.size(); k++) begin
      ech  = v.tab ? v.ch[k] : rr(v.mask, last);
      last = int'(ech);
      chk($sformatf("%s_chan%0d", tag, k), xq[qb+k].ch, ech);
      chk($sformatf("%s_data%0d", tag, k), xq[qb+k].d,
          12'({ech, 9'(cb + k)}));
      if (k == 0)
        chk({tag, "_first_smp"}, xq[qb].c, c0 + peff + 1 + SOC_C + v.lat + 5);
      else
        chk($sformatf("%s_space%0d", tag, k),
            xq[qb+k].c - xq[qb+k-1].c, sp);
    end
    start = 1'b0;
  endtask

  vec_t tv[$];
  int   f, qb, cb, rb;
  bit   seen;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_soc", adc_soc, 0);
    chk("rst_s", adc_s, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_chan", smp_chan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    tv.push_back('{8'b0010_0110, 100, 20, 4, 1'b1, ch4(1, 2, 5, 1)});
    tv.push_back('{8'b1000_0000, 30, 5, 3, 1'b1, ch4(7, 7, 7, 0)});
    tv.push_back('{8'b1111_1111, 0, 3, 4, 1'b1, ch4(0, 1, 2, 3)});
    tv.push_back('{8'b1001_0000, 50, 10, 4, 1'b1, ch4(4, 7, 4, 7)});
    for (int i = 0; i < 5; i++)
      tv.push_back('{8'($urandom_range(1, 255)), int'($urandom_range(0, 70)),
                     int'($urandom_range(1, 30)), 5, 1'b0, '0});
    for (int i = 0; i < tv.size(); i++)
      run_scan(tv[i], $sformatf("scan%0d", i));

    // timeout, clear, and clear beating a same-cycle set
    do_reset();
    chan_mask = 8'b1000_0001;
    period    = 16'd150;
    eoc_en    = 1'b0;
    rb = fall_n;
    start = 1'b1;
    wait_fall(rb + 1, "to");
    f = fall_cyc;
    chk("to_chan0", adc_s, 0);
    seen = 1'b0;
    do begin
      @(negedge clk);
      seen |= smp_valid;
    end while (cyc < f + TMO - 1);
    chk("to_err_early", err, 0);
    @(negedge clk);
    seen |= smp_valid;
    chk("to_err_set", err, 1);
    chk("to_no_valid", seen, 0);
    for (int t = 0; t < 400 && fall_n < rb + 2; t++) begin
      step();
      if (adc_soc) break;
    end
    step();
    chk("to_next_chan", adc_s, 7);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("to_err_clr", err, 0);
    wait_fall(rb + 2, "to2");
    f = fall_cyc;
    while (cyc < f + TMO - 1) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("to_clr_wins", err, 0);
    start = 1'b0;

    // overrun: three conversions against a stalled consumer
    do_reset();
    chan_mask = 8'b0000_1000;
    period    = 16'd40;
    lat       = 5;
    smp_ready = 1'b0;
    cb = conv_n;
    rb = fall_n;
    start = 1'b1;
    wait_fall(rb + 3, "ovr");
    f = fall_cyc;
    while (cyc < f + 5 + 6) step();
    @(negedge clk);
    chk("ovr_valid", smp_valid, 1);
    chk("ovr_chan", smp_chan, 3);
    chk("ovr_data", smp_data, 12'({3'd3, 9'(cb)}));
    chk("ovr_err", err, 2);
    qb = xq.size();
    step();
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
    chk("ovr_xfer_n", xq.size(), qb + 1);
    if (xq.size() > qb) chk("ovr_xfer_d", xq[qb].d, 12'({3'd3, 9'(cb)}));
    start = 1'b0;

    // consumer accepts in the very cycle the next sample is pushed
    do_reset();
    chan_mask = 8'b0000_0010;
    period    = 16'd50;
    lat       = 8;
    smp_ready = 1'b0;
    cb = conv_n;
    rb = fall_n;
    start = 1'b1;
    wait_fall(rb + 2, "sim");
    f  = fall_cyc;
    qb = xq.size();
    while (cyc < f + 8 + 3) step();
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
    @(negedge clk);
    chk("sim_valid", smp_valid, 1);
    chk("sim_new", smp_data, 12'({3'd1, 9'(cb + 1)}));
    chk("sim_err", err, 0);
    chk("sim_xfer_n", xq.size(), qb + 1);
    if (xq.size() > qb) chk("sim_old", xq[qb].d, 12'({3'd1, 9'(cb)}));
    start = 1'b0;

    // start dropped while converting
    do_reset();
    chan_mask = 8'b0000_0100;
    period    = 16'd60;
    lat       = 20;
    cb = conv_n;
    rb = fall_n;
    start = 1'b1;
    wait_fall(rb + 1, "drop");
    f = fall_cyc;
    while (cyc < f + 5) step();
    start = 1'b0;
    qb = xq.size();
    wait_xfer(qb + 1, "drop");
    if (xq.size() > qb) begin
      chk("drop_chan", xq[qb].ch, 2);
      chk("drop_data", xq[qb].d, 12'({3'd2, 9'(cb)}));
    end
    @(negedge clk);
    chk("drop_idle", busy, 0);
    rb = rise_q.size();
    repeat (150) step();
    chk("drop_no_soc", rise_q.size(), rb);
    chan_mask = '0;
    start = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= busy;
    end
    chk("mask0_busy", seen, 0);
    start = 1'b0;

    // reset pulse in the middle of a conversion
    do_reset();
    chan_mask = 8'b0110_0000;
    period    = 16'd80;
    lat       = 30;
    rb = fall_n;
    start = 1'b1;
    wait_fall(rb + 2, "mrst");
    f = fall_cyc;
    chk("mrst_pre_chan", adc_s, 6);
    while (cyc < f + 5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_soc", adc_soc, 0);
    chk("mrst_s", adc_s, 0);
    chk("mrst_valid", smp_valid, 0);
    chk("mrst_data", smp_data, 0);
    chk("mrst_chan", smp_chan, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    qb = xq.size();
    wait_xfer(qb + 1, "mrst");
    if (xq.size() > qb) chk("mrst_first_chan", xq[qb].ch, 5);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
